// File: rtl/fifo_flag.sv
// Single-clock FIFO using all 2**AWID entries, with exact occupancy, programmable
// almost-full/almost-empty thresholds, sticky error reporting and FWFT or registered read.
module fifo_flag #(
  parameter int    DWID       = 32,
  parameter int    AWID       = 10,
  parameter int    AFULL_LEV  = 2**AWID - 4,
  parameter int    AEMPTY_LEV = 4,
  parameter string FWFT       = "true"
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CLR,
  input  logic            WRENA,
  input  logic [DWID-1:0] WRDAT,
  input  logic            RDENA,
  output logic [DWID-1:0] RDDAT,
  output logic            RDVLD,
  output logic [AWID:0]   LEVEL,
  output logic            FULL,
  output logic            EMPTY,
  output logic            AFULL,
  output logic            AEMPTY,
  output logic            OVF,
  output logic            UDF,
  output logic [1:0]      ERR
);

  localparam int            DEPTH      = 2**AWID;
  localparam logic [AWID:0] AFULL_THR  = AFULL_LEV[AWID:0];
  localparam logic [AWID:0] AEMPTY_THR = AEMPTY_LEV[AWID:0];
  localparam logic [AWID:0] ONE        = {{AWID{1'b0}}, 1'b1};

  logic [DWID-1:0] mem [DEPTH];

  logic [AWID:0] wr_ptr_reg, wr_ptr_next;
  logic [AWID:0] rd_ptr_reg, rd_ptr_next;
  logic [AWID:0] level_reg, level_next;
  logic          full_reg, full_next;
  logic          empty_reg, empty_next;
  logic          afull_reg, afull_next;
  logic          aempty_reg, aempty_next;
  logic          ovf_reg, ovf_next;
  logic          udf_reg, udf_next;
  logic [1:0]    err_reg, err_next;
  logic          wr_acc;
  logic          rd_acc;

  // Acceptance looks only at the registered flags, so a read and a write in the
  // same cycle never qualify each other.
  always_comb begin
    wr_acc      = WRENA && !full_reg;
    rd_acc      = RDENA && !empty_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    full_next   = full_reg;
    empty_next  = empty_reg;
    afull_next  = afull_reg;
    aempty_next = aempty_reg;
    ovf_next    = 1'b0;
    udf_next    = 1'b0;
    err_next    = err_reg;
    if (CLR) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
      full_next   = 1'b0;
      empty_next  = 1'b1;
      afull_next  = 1'b0;
      aempty_next = 1'b1;
      err_next    = 2'b00;
    end else begin
      if (wr_acc) wr_ptr_next = wr_ptr_reg + ONE;
      if (rd_acc) rd_ptr_next = rd_ptr_reg + ONE;
      case ({wr_acc, rd_acc})
        2'b10:   level_next = level_reg + ONE;
        2'b01:   level_next = level_reg - ONE;
        default: level_next = level_reg;
      endcase
      ovf_next    = WRENA && full_reg;
      udf_next    = RDENA && empty_reg;
      err_next    = err_reg | {ovf_next, udf_next};
      // Extra pointer MSB distinguishes full from empty when the addresses match.
      full_next   = (wr_ptr_next[AWID] != rd_ptr_next[AWID]) &&
                    (wr_ptr_next[AWID-1:0] == rd_ptr_next[AWID-1:0]);
      empty_next  = (wr_ptr_next == rd_ptr_next);
      afull_next  = (level_next >= AFULL_THR);
      aempty_next = (level_next <= AEMPTY_THR);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      afull_reg  <= 1'b0;
      aempty_reg <= 1'b1;
      ovf_reg    <= 1'b0;
      udf_reg    <= 1'b0;
      err_reg    <= 2'b00;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      full_reg   <= full_next;
      empty_reg  <= empty_next;
      afull_reg  <= afull_next;
      aempty_reg <= aempty_next;
      ovf_reg    <= ovf_next;
      udf_reg    <= udf_next;
      err_reg    <= err_next;
    end
  end

  // Storage is never reset or flushed; only the pointers define valid content.
  always_ff @(posedge CLK) begin
    if (wr_acc && !CLR) mem[wr_ptr_reg[AWID-1:0]] <= WRDAT;
  end

  generate
    if (FWFT == "true") begin : g_fwft
      assign RDDAT = mem[rd_ptr_reg[AWID-1:0]];
      assign RDVLD = !empty_reg;
    end else begin : g_regrd
      logic [DWID-1:0] rddat_reg;
      logic            rdvld_reg;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          rddat_reg <= '0;
          rdvld_reg <= 1'b0;
        end else if (CLR) begin
          rdvld_reg <= 1'b0;
        end else begin
          rdvld_reg <= rd_acc;
          if (rd_acc) rddat_reg <= mem[rd_ptr_reg[AWID-1:0]];
        end
      end
      assign RDDAT = rddat_reg;
      assign RDVLD = rdvld_reg;
    end
  endgenerate

  assign LEVEL  = level_reg;
  assign FULL   = full_reg;
  assign EMPTY  = empty_reg;
  assign AFULL  = afull_reg;
  assign AEMPTY = aempty_reg;
  assign OVF    = ovf_reg;
  assign UDF    = udf_reg;
  assign ERR    = err_reg;

endmodule
